// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared encodings for the capture SRAM arbiter
package sram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } arb_state_t;

  localparam logic REQ_LOG  = 1'b0;
  localparam logic REQ_HOST = 1'b1;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

endpackage

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - logger/host arbiter and strobe sequencer for the capture SRAM
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W        = 17,
  parameter int DATA_W        = 8,
  parameter int STROBE_CYCLES = 2,
  parameter int MAX_LOG_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              log_req,
  input  logic [ADDR_W-1:0] log_addr,
  input  logic [DATA_W-1:0] log_wdata,
  output logic              log_ack,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              sram_cen,
  output logic              sram_oen,
  output logic              sram_wen,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dout,
  output logic              sram_dout_en,
  input  logic [DATA_W-1:0] sram_din
);

  localparam int CNT_W   = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
  localparam int BURST_W = $clog2(MAX_LOG_BURST + 1);

  arb_state_t          state, state_nxt;
  logic [CNT_W-1:0]    strobe_cnt;
  logic [BURST_W-1:0]  burst_cnt;
  logic                owner_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                grant;
  logic                host_wins;

  // Host only overtakes the logger once the logger has used its whole burst allowance.
  assign grant     = log_req || host_req;
  assign host_wins = host_req && (!log_req || (burst_cnt == BURST_W'(MAX_LOG_BURST)));

  assign sram_addr = addr_q;
  assign sram_dout = wdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      strobe_cnt <= '0;
      burst_cnt  <= '0;
      owner_q    <= REQ_LOG;
      we_q       <= CMD_READ;
      addr_q     <= '0;
      wdata_q    <= '0;
      host_rdata <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (grant) begin
            owner_q <= host_wins ? REQ_HOST : REQ_LOG;
            we_q    <= host_wins ? host_we : CMD_WRITE;
            addr_q  <= host_wins ? host_addr : log_addr;
            wdata_q <= host_wins ? host_wdata : log_wdata;
          end
          if (!host_req || host_wins) begin
            burst_cnt <= '0;
          end else if (burst_cnt != BURST_W'(MAX_LOG_BURST)) begin
            burst_cnt <= burst_cnt + 1'b1;
          end
        end
        ST_SETUP: strobe_cnt <= CNT_W'(STROBE_CYCLES - 1);
        ST_STROBE: begin
          strobe_cnt <= strobe_cnt - 1'b1;
          if (strobe_cnt == '0 && !we_q) begin
            host_rdata <= sram_din;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt    = state;
    sram_cen     = 1'b0;
    sram_oen     = 1'b0;
    sram_wen     = 1'b0;
    sram_dout_en = 1'b0;
    log_ack      = 1'b0;
    host_ack     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant) state_nxt = ST_SETUP;
      end
      ST_SETUP: begin
        sram_cen     = 1'b1;
        sram_dout_en = we_q;
        state_nxt    = ST_STROBE;
      end
      ST_STROBE: begin
        sram_cen     = 1'b1;
        sram_dout_en = we_q;
        sram_wen     = we_q;
        sram_oen     = !we_q;
        if (strobe_cnt == '0) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        sram_cen     = 1'b1;
        sram_dout_en = we_q;
        log_ack      = (owner_q == REQ_LOG);
        host_ack     = (owner_q == REQ_HOST);
        state_nxt    = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - self-checking bench for sram_arbiter
module tb_sram_arbiter;

  localparam int AW = 17;
  localparam int DW = 8;
  localparam int SC = 2;
  localparam int MB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          log_req, log_ack;
  logic [AW-1:0] log_addr;
  logic [DW-1:0] log_wdata;
  logic          host_req, host_we, host_ack;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata, host_rdata;
  logic          sram_cen, sram_oen, sram_wen, sram_dout_en;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_dout, sram_din;

  logic          b_req;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic          s1_log_ack, s1_host_ack, s1_cen, s1_oen, s1_wen, s1_den;
  logic [AW-1:0] s1_addr;
  logic [DW-1:0] s1_dout, s1_rdata;
  logic          s5_log_ack, s5_host_ack, s5_cen, s5_oen, s5_wen, s5_den;
  logic [AW-1:0] s5_addr;
  logic [DW-1:0] s5_dout, s5_rdata;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [16];
  int n_checks = 0;
  int n_fail   = 0;
  int inv_bad  = 0;
  int m_burst  = 0;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STROBE_CYCLES(SC), .MAX_LOG_BURST(MB)) u_dut (
    .clk(clk), .rst(rst),
    .log_req(log_req), .log_addr(log_addr), .log_wdata(log_wdata), .log_ack(log_ack),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata),
    .sram_cen(sram_cen), .sram_oen(sram_oen), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_dout(sram_dout), .sram_dout_en(sram_dout_en), .sram_din(sram_din)
  );

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STROBE_CYCLES(1), .MAX_LOG_BURST(MB)) u_s1 (
    .clk(clk), .rst(rst),
    .log_req(b_req), .log_addr(b_addr), .log_wdata(b_wdata), .log_ack(s1_log_ack),
    .host_req(1'b0), .host_we(1'b0), .host_addr(17'h0), .host_wdata(8'h0),
    .host_ack(s1_host_ack), .host_rdata(s1_rdata),
    .sram_cen(s1_cen), .sram_oen(s1_oen), .sram_wen(s1_wen), .sram_addr(s1_addr),
    .sram_dout(s1_dout), .sram_dout_en(s1_den), .sram_din(8'h0)
  );

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STROBE_CYCLES(5), .MAX_LOG_BURST(MB)) u_s5 (
    .clk(clk), .rst(rst),
    .log_req(b_req), .log_addr(b_addr), .log_wdata(b_wdata), .log_ack(s5_log_ack),
    .host_req(1'b0), .host_we(1'b0), .host_addr(17'h0), .host_wdata(8'h0),
    .host_ack(s5_host_ack), .host_rdata(s5_rdata),
    .sram_cen(s5_cen), .sram_oen(s5_oen), .sram_wen(s5_wen), .sram_addr(s5_addr),
    .sram_dout(s5_dout), .sram_dout_en(s5_den), .sram_din(8'h0)
  );

  // Behavioural SRAM behind the main instance.
  always @(posedge clk) if (sram_cen && sram_wen) mem[sram_addr] = sram_dout;
  assign sram_din = sram_oen ? mem[sram_addr] : 8'h00;

  always @(negedge clk) begin
    if ((sram_oen && sram_dout_en) || (sram_oen && sram_wen)) inv_bad++;
    if ((sram_oen || sram_wen) && !sram_cen) inv_bad++;
    if (log_ack && host_ack) inv_bad++;
    if (s1_host_ack || s5_host_ack || s1_oen || s5_oen) inv_bad++;
    if (s1_rdata != 8'h00 || s5_rdata != 8'h00) inv_bad++;
    if (s1_cen && (s1_addr != b_addr || (s1_den && s1_dout != b_wdata))) inv_bad++;
    if (s5_cen && (s5_addr != b_addr || (s5_den && s5_dout != b_wdata))) inv_bad++;
    if ((s1_wen && !s1_den) || (s5_wen && !s5_den)) inv_bad++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string p);
    chk($sformatf("%s cen", p), 32'(sram_cen), 0);
    chk($sformatf("%s oen", p), 32'(sram_oen), 0);
    chk($sformatf("%s wen", p), 32'(sram_wen), 0);
    chk($sformatf("%s dout_en", p), 32'(sram_dout_en), 0);
    chk($sformatf("%s addr", p), 32'(sram_addr), 0);
    chk($sformatf("%s dout", p), 32'(sram_dout), 0);
    chk($sformatf("%s log_ack", p), 32'(log_ack), 0);
    chk($sformatf("%s host_ack", p), 32'(host_ack), 0);
    chk($sformatf("%s host_rdata", p), 32'(host_rdata), 0);
  endtask

  // Arbitration rule at transaction level: logger preferred, host forced after MB logger grants.
  task automatic model_grant(input bit lr, input bit hr, output bit host);
    if (hr && (!lr || m_burst == MB)) begin
      host = 1'b1;
      m_burst = 0;
    end else begin
      host = 1'b0;
      m_burst = hr ? ((m_burst < MB) ? m_burst + 1 : MB) : 0;
    end
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          pre;
    logic [DW-1:0] preload;
    logic [DW-1:0] exp_rdata;
    int            exp_lat;
    int            exp_wen;
    int            exp_oen;
    int            exp_den;
  } hvec_t;

  task automatic run_hvec(input hvec_t v, input string p);
    int lat = -1, wen_c = 0, oen_c = 0, den_c = 0, stray = 0;
    int fld_bad = 0;
    tick();
    if (v.pre) mem[v.addr] = v.preload;
    host_req = 1'b1; host_we = v.we; host_addr = v.addr; host_wdata = v.wdata;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      wen_c += int'(sram_wen);
      oen_c += int'(sram_oen);
      den_c += int'(sram_dout_en);
      if (sram_cen && (sram_addr != v.addr || (v.we && sram_dout != v.wdata))) fld_bad++;
      if (log_ack) stray++;
      if (host_ack) begin lat = n; break; end
    end
    host_req = 1'b0;
    chk($sformatf("%s latency", p), 32'(lat), 32'(v.exp_lat));
    chk($sformatf("%s wen cycles", p), 32'(wen_c), 32'(v.exp_wen));
    chk($sformatf("%s oen cycles", p), 32'(oen_c), 32'(v.exp_oen));
    chk($sformatf("%s dout_en cycles", p), 32'(den_c), 32'(v.exp_den));
    chk($sformatf("%s addr/dout", p), 32'(fld_bad), 0);
    chk($sformatf("%s log_ack stray", p), 32'(stray), 0);
    chk($sformatf("%s rdata at ack", p), 32'(host_rdata), 32'(v.exp_rdata));
    @(negedge clk);
    chk($sformatf("%s rdata held", p), 32'(host_rdata), 32'(v.exp_rdata));
    if (v.we) chk($sformatf("%s sram contents", p), 32'(mem[v.addr]), 32'(v.wdata));
  endtask

  hvec_t vecs[7];

  initial begin
    bit lr, hr, hwe, pick_host, got_host;
    int lo, ho, ack_n, k, last, k1, k5;
    logic [DW-1:0] lw, hw;
    bit exp_h[10], got_h[10];
    int t1[2], t5[2];

    rst = 1'b1; log_req = 1'b0; log_addr = '0; log_wdata = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    b_req = 1'b0; b_addr = 17'h00300; b_wdata = 8'h96;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle("idle");

    vecs[0] = '{1'b1, 17'h1ABCD, 8'h5A, 1'b0, 8'h00, 8'h00, SC+2, SC, 0,  SC+2};
    vecs[1] = '{1'b0, 17'h00010, 8'h00, 1'b1, 8'hC3, 8'hC3, SC+2, 0,  SC, 0};
    vecs[2] = '{1'b1, 17'h1FFFF, 8'hA5, 1'b0, 8'h00, 8'hC3, SC+2, SC, 0,  SC+2};
    vecs[3] = '{1'b0, 17'h00000, 8'h00, 1'b1, 8'h3C, 8'h3C, SC+2, 0,  SC, 0};
    vecs[4] = '{1'b0, 17'h1ABCD, 8'h00, 1'b0, 8'h00, 8'h5A, SC+2, 0,  SC, 0};
    vecs[5] = '{1'b1, 17'h00000, 8'hFF, 1'b0, 8'h00, 8'h5A, SC+2, SC, 0,  SC+2};
    vecs[6] = '{1'b0, 17'h00000, 8'h00, 1'b0, 8'h00, 8'hFF, SC+2, 0,  SC, 0};
    for (int i = 0; i < 7; i++) run_hvec(vecs[i], $sformatf("vec%0d", i));

    // Simultaneous requests: logger first, host right after the logger's HOLD.
    tick();
    log_req = 1'b1; log_addr = 17'h00400; log_wdata = 8'h11;
    host_req = 1'b1; host_we = 1'b1; host_addr = 17'h00401; host_wdata = 8'h22;
    k1 = -1; k5 = -1;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (log_ack) begin k1 = n; log_req = 1'b0; end
      if (host_ack) begin k5 = n; host_req = 1'b0; break; end
    end
    log_req = 1'b0; host_req = 1'b0;
    chk("same-cycle log ack", 32'(k1), 32'(SC + 2));
    chk("same-cycle host ack", 32'(k5), 32'(2 * SC + 5));
    chk("same-cycle log data", 32'(mem[17'h00400]), 32'h11);
    chk("same-cycle host data", 32'(mem[17'h00401]), 32'h22);

    // Both held high: burst limit decides the grant sequence.
    repeat (2) tick();
    log_req = 1'b1; log_addr = 17'h00500; log_wdata = 8'h33;
    host_req = 1'b1; host_we = 1'b0; host_addr = 17'h00500;
    m_burst = 0; k = 0; last = -1;
    for (int i = 0; i < 10; i++) model_grant(1'b1, 1'b1, exp_h[i]);
    for (int n = 0; n < 200 && k < 10; n++) begin
      @(negedge clk);
      if (log_ack || host_ack) begin got_h[k] = host_ack; last = n; k++; end
    end
    log_req = 1'b0; host_req = 1'b0;
    chk("burst grant count", 32'(k), 10);
    for (int i = 0; i < 10; i++) chk($sformatf("burst grant %0d is host", i), 32'(got_h[i]), 32'(exp_h[i]));
    chk("burst last ack cycle", 32'(last), 32'(SC + 2 + 9 * (SC + 3)));

    // Randomized traffic against the transaction-level model.
    repeat (2) tick();
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = 8'($urandom);
      mem[17'h00100 + 17'(i)] = ref_mem[i];
    end
    lr = 1'b0; hr = 1'b0; m_burst = 0;
    lo = 0; ho = 0; lw = '0; hw = '0; hwe = 1'b0;
    for (int r = 0; r < 60; r++) begin
      if (!lr && $urandom_range(0, 1) == 1) begin
        lr = 1'b1; lo = $urandom_range(0, 15); lw = 8'($urandom);
      end
      if (!hr && $urandom_range(0, 1) == 1) begin
        hr = 1'b1; ho = $urandom_range(0, 15); hw = 8'($urandom); hwe = 1'($urandom_range(0, 1));
      end
      log_req = lr; log_addr = 17'h00100 + 17'(lo); log_wdata = lw;
      host_req = hr; host_we = hwe; host_addr = 17'h00100 + 17'(ho); host_wdata = hw;
      if (!lr && !hr) begin
        m_burst = 0;
        tick();
        continue;
      end
      model_grant(lr, hr, pick_host);
      ack_n = -1; got_host = 1'b0;
      for (int n = 0; n < 12; n++) begin
        @(negedge clk);
        if (n == 1) begin
          if (pick_host) begin
            host_we = ~hwe; host_addr = ~host_addr; host_wdata = ~hw;
          end else begin
            log_addr = ~log_addr; log_wdata = ~lw;
          end
        end
        if (log_ack || host_ack) begin ack_n = n; got_host = host_ack; break; end
      end
      chk($sformatf("rand%0d latency", r), 32'(ack_n), 32'(SC + 2));
      chk($sformatf("rand%0d winner is host", r), 32'(got_host), 32'(pick_host));
      if (pick_host) begin
        if (!hwe) chk($sformatf("rand%0d rdata", r), 32'(host_rdata), 32'(ref_mem[ho]));
        else ref_mem[ho] = hw;
        hr = 1'b0; host_req = 1'b0;
      end else begin
        ref_mem[lo] = lw;
        lr = 1'b0; log_req = 1'b0;
      end
      tick();
    end
    log_req = 1'b0; host_req = 1'b0;
    for (int i = 0; i < 16; i++)
      chk($sformatf("rand sram[%0d]", i), 32'(mem[17'h00100 + 17'(i)]), 32'(ref_mem[i]));

    // Reset during the second STROBE cycle of a logger write.
    repeat (2) tick();
    log_req = 1'b1; log_addr = 17'h00600; log_wdata = 8'h77;
    for (int n = 0; n < 4; n++) @(negedge clk);
    chk("abort wen before rst", 32'(sram_wen), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort wen", 32'(sram_wen), 0);
    chk("abort cen", 32'(sram_cen), 0);
    chk("abort dout_en", 32'(sram_dout_en), 0);
    chk("abort log_ack", 32'(log_ack), 0);
    rst = 1'b0; log_req = 1'b0;
    k = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      k += int'(log_ack);
    end
    chk("abort no late ack", 32'(k), 0);
    run_hvec('{1'b1, 17'h00700, 8'hE1, 1'b0, 8'h00, 8'h00, SC+2, SC, 0, SC+2}, "post-reset");

    // STROBE_CYCLES = 1 and 5 builds: latency and back-to-back period.
    tick();
    b_req = 1'b1;
    k1 = 0; k5 = 0; t1 = '{-1, -1}; t5 = '{-1, -1};
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (s1_log_ack && k1 < 2) begin t1[k1] = n; k1++; end
      if (s5_log_ack && k5 < 2) begin t5[k5] = n; k5++; end
    end
    b_req = 1'b0;
    chk("strobe1 latency", 32'(t1[0]), 3);
    chk("strobe1 period", 32'(t1[1] - t1[0]), 4);
    chk("strobe5 latency", 32'(t5[0]), 7);
    chk("strobe5 period", 32'(t5[1] - t5[0]), 8);

    repeat (12) @(negedge clk);
    chk("pin invariants", 32'(inv_bad), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
